// File: rtl/conv_weight_fetch_pkg.sv
// Shared conv definitions: weight word geometry and the fetch sequencer states.
package conv_weight_fetch_pkg;

  localparam int WEIGHT_WORD_W = 144;
  localparam int TAP_W         = 16;
  localparam int TAPS          = 9;
  localparam int WEIGHT_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/conv_weight_fetch_fifo.sv
// Show-ahead FIFO buffering ROM words ahead of the conv engine.
// The head entry is always on pop_data; a push into an empty FIFO shows up
// on pop_data one cycle later (no bypass path).
module conv_weight_fifo #(
  parameter int DATA_WIDTH = 144,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         pop,
  output logic [DATA_WIDTH-1:0]        pop_data,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv_weight_fetch.sv
// Weight fetch sequencer: walks a block of ROM addresses, hides the ROM read
// latency behind a credit-limited FIFO and streams 3x3 kernel words out.
module conv_weight_fetch
  import conv_weight_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = WEIGHT_ADDR_W,
  parameter int DATA_WIDTH  = WEIGHT_WORD_W,
  parameter int ROM_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_last
);

  localparam int NW = ADDR_WIDTH + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e state, state_nxt;

  logic [ADDR_WIDTH-1:0] base_q;
  logic [NW-1:0]         num_q;
  logic [NW-1:0]         issued_q;
  logic [NW-1:0]         popped_q;
  logic [NW-1:0]         popped_nxt;
  logic [CW-1:0]         inflight_q;
  logic [CW:0]           credit_used;
  logic                  credit_ok;
  logic                  accept;
  logic                  issue;
  logic                  push;
  logic                  pop_fire;
  // vld_pipe[0] marks a cycle where rom_addr carries a fresh read; the flag
  // reaches vld_pipe[ROM_LATENCY] in the cycle rom_rd_data holds that word.
  logic [ROM_LATENCY:0]  vld_pipe;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign accept      = (state == IDLE) && start;
  assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign credit_ok   = int'(credit_used) < FIFO_DEPTH;
  assign push        = vld_pipe[ROM_LATENCY] && !fifo_full;
  assign w_valid     = !fifo_empty;
  assign pop_fire    = w_valid && w_ready;
  assign popped_nxt  = popped_q + NW'(pop_fire);
  assign w_last      = w_valid && (popped_q == num_q - NW'(1));
  assign busy        = (state == FETCH) || (state == DRAIN);
  assign done        = (state == FINISH);

  // Next state and read-issue decision; the issued read appears on rom_addr
  // next cycle, so the first read goes out straight from the accepting cycle.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            issue     = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = FINISH;
          end
        end
      end
      FETCH: begin
        if (issued_q < num_q && credit_ok) issue = 1'b1;
        if (issued_q == num_q) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (popped_nxt == num_q) state_nxt = FINISH;
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job control: state, latched job parameters, issue/pop progress counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      base_q   <= '0;
      num_q    <= '0;
      issued_q <= '0;
      popped_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        base_q   <= base_addr;
        num_q    <= num_words;
        issued_q <= NW'(issue);
        popped_q <= '0;
      end else begin
        issued_q <= issued_q + NW'(issue);
        popped_q <= popped_nxt;
      end
    end
  end

  // Read address register and in-flight tracking; reset drops pending reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_addr   <= '0;
      vld_pipe   <= '0;
      inflight_q <= '0;
    end else begin
      if (issue) rom_addr <= accept ? base_addr : base_q + issued_q[ADDR_WIDTH-1:0];
      vld_pipe <= {vld_pipe[ROM_LATENCY-1:0], issue};
      case ({issue, vld_pipe[ROM_LATENCY]})
        2'b10:   inflight_q <= inflight_q + CW'(1);
        2'b01:   inflight_q <= inflight_q - CW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  conv_weight_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (rom_rd_data),
    .pop       (pop_fire),
    .pop_data  (w_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_conv_weight_fetch.sv
// Directed bench for conv_weight_fetch with a 1-cycle-latency ROM model.
module tb_conv_weight_fetch;

  localparam int DW = 144;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    base_addr = '0;
  logic [8:0]    num_words = '0;
  logic          busy;
  logic          done;
  logic [7:0]    rom_addr;
  logic [DW-1:0] rom_rd_data;
  logic          w_valid;
  logic          w_ready = 1'b0;
  logic [DW-1:0] w_data;
  logic          w_last;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  conv_weight_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .num_words   (num_words),
    .busy        (busy),
    .done        (done),
    .rom_addr    (rom_addr),
    .rom_rd_data (rom_rd_data),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_data      (w_data),
    .w_last      (w_last)
  );

  // ROM contents: each tap carries its address and tap index.
  function automatic logic [DW-1:0] rom_word(input logic [7:0] a);
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*16 +: 16] = {a, 4'(k), 4'hA};
    return w;
  endfunction

  always @(posedge clk) rom_rd_data <= rom_word(rom_addr);

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready high; 1: ready low in cycles 4..12; 2: ready high plus a
  // stray start in cycle 5; 3: random ready.
  task automatic run_job(input logic [7:0] b, input logic [8:0] n, input int mode, input int budget);
    int c, k;
    bit fin;
    logic [7:0] exp_a;
    start = 1'b1; base_addr = b; num_words = n;
    c = 0; k = 0; fin = 1'b0;
    while (!fin && c < budget) begin
      case (mode)
        1:       w_ready = !(c >= 4 && c <= 12);
        3:       w_ready = 1'($urandom_range(0, 1));
        default: w_ready = 1'b1;
      endcase
      if (mode == 2 && c == 5) begin
        start = 1'b1; base_addr = 8'h77; num_words = 9'd3;
      end
      if (mode == 1 && c == 12) begin
        exp_a = b + 8'd4;
        chk("stall_issue_addr", rom_addr, exp_a);
        exp_a = b + 8'd1;
        chk("stall_hold_data", w_data, rom_word(exp_a));
        chk("stall_valid", w_valid, 1'b1);
        chk("stall_pops", k, 1);
      end
      if (w_valid && w_ready) begin
        exp_a = b + k[7:0];
        chk("pop_data", w_data, rom_word(exp_a));
        chk("pop_last", w_last, (k == int'(n) - 1));
        k++;
      end
      if (done) fin = 1'b1;
      cyc;
      c++;
      start = 1'b0;
    end
    chk("job_timeout", fin, 1'b1);
    chk("job_words", k, int'(n));
    chk("done_single", done, 1'b0);
    chk("busy_after", busy, 1'b0);
  endtask

  initial begin
    w_ready = 1'b1;
    repeat (2) cyc;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_valid", w_valid, 1'b0);
    chk("rst_last", w_last, 1'b0);
    chk("rst_addr", rom_addr, 8'h00);
    rst_n = 1'b1;
    cyc;

    // Job 1: base 0x10, 4 words, cycle-exact timing.
    start = 1'b1; base_addr = 8'h10; num_words = 9'd4;
    cyc; start = 1'b0;                                   // cycle 1
    chk("t1_c1_addr", rom_addr, 8'h10);
    chk("t1_c1_busy", busy, 1'b1);
    chk("t1_c1_valid", w_valid, 1'b0);
    cyc;                                                 // cycle 2
    chk("t1_c2_addr", rom_addr, 8'h11);
    chk("t1_c2_valid", w_valid, 1'b0);
    cyc;                                                 // cycle 3
    chk("t1_c3_addr", rom_addr, 8'h12);
    chk("t1_c3_valid", w_valid, 1'b1);
    chk("t1_c3_data", w_data, rom_word(8'h10));
    chk("t1_c3_last", w_last, 1'b0);
    cyc;                                                 // cycle 4
    chk("t1_c4_addr", rom_addr, 8'h13);
    chk("t1_c4_data", w_data, rom_word(8'h11));
    cyc;                                                 // cycle 5
    chk("t1_c5_addr_hold", rom_addr, 8'h13);
    chk("t1_c5_data", w_data, rom_word(8'h12));
    cyc;                                                 // cycle 6
    chk("t1_c6_data", w_data, rom_word(8'h13));
    chk("t1_c6_last", w_last, 1'b1);
    chk("t1_c6_done", done, 1'b0);
    cyc;                                                 // cycle 7
    chk("t1_c7_done", done, 1'b1);
    chk("t1_c7_busy", busy, 1'b0);
    chk("t1_c7_valid", w_valid, 1'b0);
    cyc;
    chk("t1_c8_done", done, 1'b0);

    // Job 2: address wrap 0xFE..0x01.
    run_job(8'hFE, 9'd4, 0, 50);
    chk("t2_final_addr", rom_addr, 8'h01);

    // Job 3: backpressure in cycles 4..12.
    run_job(8'h20, 9'd8, 1, 100);
    chk("t3_final_addr", rom_addr, 8'h27);

    // Job 4: zero-length job.
    start = 1'b1; base_addr = 8'h99; num_words = 9'd0;
    cyc; start = 1'b0;
    chk("t4_done", done, 1'b1);
    chk("t4_busy", busy, 1'b0);
    chk("t4_addr", rom_addr, 8'h27);
    chk("t4_valid", w_valid, 1'b0);
    cyc;
    chk("t4_done_clear", done, 1'b0);
    chk("t4_addr_hold", rom_addr, 8'h27);
    chk("t4_valid_low", w_valid, 1'b0);

    // Job with a stray start while busy.
    run_job(8'h50, 9'd6, 2, 100);
    chk("ign_final_addr", rom_addr, 8'h55);

    // Job 5: reset after three pops.
    w_ready = 1'b1;
    start = 1'b1; base_addr = 8'h30; num_words = 9'd8;
    repeat (6) begin
      cyc; start = 1'b0;
    end
    chk("t5_pre_valid", w_valid, 1'b1);
    chk("t5_pre_data", w_data, rom_word(8'h33));
    rst_n = 1'b0;
    cyc; rst_n = 1'b1;
    chk("t5_rst_valid", w_valid, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_done", done, 1'b0);
    chk("t5_rst_addr", rom_addr, 8'h00);
    repeat (3) begin
      cyc;
      chk("t5_idle_valid", w_valid, 1'b0);
      chk("t5_idle_done", done, 1'b0);
    end
    run_job(8'h40, 9'd2, 0, 30);

    // Job 6: full 256-word sweep under random backpressure.
    run_job(8'h00, 9'd256, 3, 3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
